// File: rtl/ser2par_rr_arbiter.sv
// Round-robin shared 8-bit serial-to-parallel capture path for NUM_CH serial requesters.
// One channel owns the path per frame; the byte is emitted tagged with its source channel.
module ser2par_rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] din_serial,
  input  logic [NUM_CH-1:0] din_valid,
  output logic [NUM_CH-1:0] gnt,
  output logic [7:0]        dout_parallel,
  output logic [CH_W-1:0]   dout_ch,
  output logic              dout_valid,
  output logic              frame_err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SUM_W  = CH_W + 1;

  typedef enum logic {
    ST_IDLE,
    ST_RECV
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CH_W-1:0]     r_ptr, w_ptr_nxt;
  logic [CH_W-1:0]     r_owner, w_owner_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [BYTE_W-1:0]   r_shreg, w_shreg_nxt;
  logic [NUM_CH-1:0]   r_gnt, w_gnt_nxt;
  logic [BYTE_W-1:0]   r_dout, w_dout_nxt;
  logic [CH_W-1:0]     r_dout_ch, w_dout_ch_nxt;
  logic                r_dout_valid, w_dout_valid_nxt;
  logic                r_frame_err, w_frame_err_nxt;

  logic                w_found;
  logic [CH_W-1:0]     w_sel;
  logic [SUM_W-1:0]    w_sum;
  logic [CH_W-1:0]     w_cand;
  logic                w_bit;
  logic                w_bit_vld;
  logic [BYTE_W-1:0]   w_shifted;

  // First requesting channel at or above the pointer, wrapping explicitly at NUM_CH.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      w_sum  = SUM_W'({1'b0, r_ptr}) + SUM_W'(i);
      w_cand = (w_sum >= SUM_W'(NUM_CH)) ? CH_W'(w_sum - SUM_W'(NUM_CH)) : CH_W'(w_sum);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  assign w_bit     = din_serial[r_owner];
  assign w_bit_vld = din_valid[r_owner];
  assign w_shifted = {r_shreg[BYTE_W-2:0], w_bit};

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_owner_nxt      = r_owner;
    w_cnt_nxt        = r_cnt;
    w_shreg_nxt      = r_shreg;
    w_gnt_nxt        = r_gnt;
    w_dout_nxt       = r_dout;
    w_dout_ch_nxt    = r_dout_ch;
    w_dout_valid_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_gnt_nxt = '0;
        w_cnt_nxt = '0;
        if (w_found) begin
          w_gnt_nxt   = NUM_CH'(1) << w_sel;
          w_owner_nxt = w_sel;
          w_ptr_nxt   = (w_sel == CH_W'(NUM_CH - 1)) ? '0 : CH_W'(w_sel + CH_W'(1));
          w_state_nxt = ST_RECV;
        end
      end
      ST_RECV: begin
        if (w_bit_vld) begin
          w_shreg_nxt = w_shifted;
          w_cnt_nxt   = CNT_W'(r_cnt + CNT_W'(1));
          if (r_cnt == CNT_W'(7)) begin
            w_dout_nxt       = w_shifted;
            w_dout_ch_nxt    = r_owner;
            w_dout_valid_nxt = 1'b1;
            w_gnt_nxt        = '0;
            w_state_nxt      = ST_IDLE;
          end
        end else begin
          // Abort: partial bits are dropped, the pointer already moved past this owner.
          w_frame_err_nxt = 1'b1;
          w_gnt_nxt       = '0;
          w_shreg_nxt     = '0;
          w_cnt_nxt       = '0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_gnt        <= '0;
      r_dout       <= '0;
      r_dout_ch    <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_owner      <= w_owner_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_gnt        <= w_gnt_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_ch    <= w_dout_ch_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
    end
  end

  assign gnt           = r_gnt;
  assign dout_parallel = r_dout;
  assign dout_ch       = r_dout_ch;
  assign dout_valid    = r_dout_valid;
  assign frame_err     = r_frame_err;

endmodule

// File: tb/tb_ser2par_rr_arbiter.sv
// Bench for ser2par_rr_arbiter: per-channel frame queues drive the requesters, and a
// frame-level model (grant edge + frame length) predicts every output each cycle.
module tb_ser2par_rr_arbiter;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  typedef struct {
    logic [7:0]  data;
    int unsigned abort_k;  // 0 = full frame, k = din_valid low at the k-th bit edge
  } frame_t;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] din_serial;
  logic [NUM_CH-1:0] din_valid;
  logic [NUM_CH-1:0] gnt;
  logic [7:0]        dout_parallel;
  logic [CH_W-1:0]   dout_ch;
  logic              dout_valid;
  logic              frame_err;

  ser2par_rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .din_serial    (din_serial),
    .din_valid     (din_valid),
    .gnt           (gnt),
    .dout_parallel (dout_parallel),
    .dout_ch       (dout_ch),
    .dout_valid    (dout_valid),
    .frame_err     (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks;
  int unsigned n_fail;
  int          cyc;

  frame_t      q_fr [NUM_CH][$];
  bit          m_act;
  int unsigned m_owner;
  int unsigned m_ptr;
  int          m_g;
  int          m_end;
  frame_t      m_cur;
  logic [7:0]  m_dout;
  int unsigned m_ch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input logic [7:0] d, input int unsigned k);
    frame_t f;
    f.data    = d;
    f.abort_k = k;
    q_fr[c].push_back(f);
  endtask

  function automatic bit any_pending();
    for (int unsigned c = 0; c < NUM_CH; c++)
      if (q_fr[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: advance the model for this edge, compare, then drive inputs for the next edge.
  task automatic step();
    logic [NUM_CH-1:0] exp_gnt;
    bit                exp_v;
    bit                exp_e;
    bit                found;
    int unsigned       i;
    @(posedge clk);
    #1;
    cyc++;
    exp_v = 1'b0;
    exp_e = 1'b0;
    if (m_act) begin
      if (cyc == m_end) begin
        if (m_cur.abort_k == 0) begin
          exp_v  = 1'b1;
          m_dout = m_cur.data;
          m_ch   = m_owner;
        end else begin
          exp_e = 1'b1;
        end
        m_act = 1'b0;
        void'(q_fr[m_owner].pop_front());
      end
    end else if (req != '0) begin
      found = 1'b0;
      for (int unsigned off = 0; off < NUM_CH; off++) begin
        int unsigned c;
        c = (m_ptr + off) % NUM_CH;
        if (!found && req[c] && q_fr[c].size() != 0) begin
          found   = 1'b1;
          m_owner = c;
        end
      end
      if (found) begin
        m_ptr = (m_owner + 1) % NUM_CH;
        m_cur = q_fr[m_owner][0];
        m_g   = cyc;
        m_end = cyc + ((m_cur.abort_k == 0) ? 8 : int'(m_cur.abort_k));
        m_act = 1'b1;
      end
    end
    exp_gnt = m_act ? (NUM_CH'(1) << m_owner) : '0;
    check("gnt",           32'(gnt),           32'(exp_gnt));
    check("dout_valid",    32'(dout_valid),    32'(exp_v));
    check("frame_err",     32'(frame_err),     32'(exp_e));
    check("dout_parallel", 32'(dout_parallel), 32'(m_dout));
    check("dout_ch",       32'(dout_ch),       32'(m_ch));

    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (m_act && c == m_owner) begin
        i      = int'(cyc - m_g);
        req[c] = 1'($urandom_range(0, 1));
        if (m_cur.abort_k != 0 && i == m_cur.abort_k - 1) begin
          din_valid[c]  = 1'b0;
          din_serial[c] = 1'($urandom_range(0, 1));
        end else begin
          din_valid[c]  = 1'b1;
          din_serial[c] = m_cur.data[7 - i];
        end
      end else begin
        req[c]        = (q_fr[c].size() != 0);
        din_valid[c]  = 1'($urandom_range(0, 1));
        din_serial[c] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((m_act || any_pending()) && n < budget) begin
      step();
      n++;
    end
    check("drain_idle", 32'(m_act || any_pending()), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"},   32'(gnt),           32'd0);
    check({tag, "_dout"},  32'(dout_parallel), 32'd0);
    check({tag, "_ch"},    32'(dout_ch),       32'd0);
    check({tag, "_valid"}, 32'(dout_valid),    32'd0);
    check({tag, "_err"},   32'(frame_err),     32'd0);
  endtask

  task automatic model_reset();
    m_act  = 1'b0;
    m_ptr  = 0;
    m_dout = '0;
    m_ch   = 0;
    for (int unsigned c = 0; c < NUM_CH; c++) q_fr[c].delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wait_n;
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    rst_n      = 1'b0;
    req        = '0;
    din_serial = '0;
    din_valid  = '0;
    model_reset();
    #3;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    push(2, 8'hA5, 0);
    drain(60);

    for (int rep = 0; rep < 2; rep++)
      for (int unsigned c = 0; c < NUM_CH; c++) push(c, 8'(17 * (c + 1)), 0);
    drain(200);

    push(3, 8'h77, 0);
    drain(60);
    push(0, 8'h0F, 0);
    push(3, 8'hF0, 0);
    drain(60);

    push(1, 8'h96, 6);
    push(2, 8'h5A, 0);
    drain(60);

    push(0, 8'h3C, 0);
    drain(60);

    repeat (1500) begin
      for (int unsigned c = 0; c < NUM_CH; c++)
        if (q_fr[c].size() < 2 && $urandom_range(0, 7) == 0)
          push(c, 8'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0);
      step();
    end
    drain(2000);

    // Reset after four bits of a ch2 frame; dout_parallel is nonzero beforehand.
    push(2, 8'hC3, 0);
    wait_n = 0;
    while (!(m_act && m_owner == 2 && (cyc - m_g) == 4) && wait_n < 60) begin
      step();
      wait_n++;
    end
    check("reach_mid_frame", 32'(m_act && m_owner == 2 && (cyc - m_g) == 4), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    model_reset();
    req        = '0;
    din_valid  = '0;
    din_serial = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    push(1, 8'hAB, 0);
    push(2, 8'hCD, 0);
    drain(60);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
